// File: rtl/arm_pkg.sv
// Shared types and constants for the hazard scoreboard slice.
package arm_pkg;

  localparam int unsigned REG_AW_DEF = 4;
  // Stage entries carry a fixed-width dest field; narrower register addresses are zero-extended.
  localparam int unsigned REG_AW_MAX = 8;
  // Forwarding select value meaning "read the register file".
  localparam int unsigned FWD_SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] dest;
    logic                  wb_en;
    logic                  mem_r_en;
  } stage_entry_t;

endpackage

// File: rtl/scoreboard_match.sv
// Compares one source register against every in-flight stage; reports per-stage hits and
// the index of the youngest (lowest-numbered) matching stage.
module scoreboard_match
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [REG_AW_MAX-1:0]   src,
  input  logic                    src_used,
  input  stage_entry_t [DEPTH-1:0] stages,
  output logic [DEPTH-1:0]        hit,
  output logic [IDX_W-1:0]        youngest
);

  // Per-stage match, then scan oldest-to-youngest so the youngest hit is the final write.
  always_comb begin
    hit      = '0;
    youngest = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit[i] = src_used && stages[i].valid && stages[i].wb_en && (stages[i].dest == src);
    end
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (hit[i]) youngest = IDX_W'(i);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destinations of in-flight instructions after ID and decides stall / forwarding
// for the instruction currently in ID.
module hazard_scoreboard
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         issue_valid,
  input  logic [REG_AW-1:0]            issue_dest,
  input  logic                         issue_wb_en,
  input  logic                         issue_mem_r_en,
  input  logic [REG_AW-1:0]            src1,
  input  logic [REG_AW-1:0]            src2,
  input  logic                         src1_used,
  input  logic                         src2_used,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel1,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_sel2,
  output logic [CNT_W-1:0]             stall_count
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  stage_entry_t [DEPTH-1:0] stages_q, stages_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic [DEPTH-1:0] hit1, hit2;
  logic [SEL_W-1:0] young1, young2;
  logic             hit_any1, hit_any2;
  logic             load_use;

  scoreboard_match #(
    .DEPTH (DEPTH),
    .IDX_W (SEL_W)
  ) u_match1 (
    .src      (REG_AW_MAX'(src1)),
    .src_used (src1_used),
    .stages   (stages_q),
    .hit      (hit1),
    .youngest (young1)
  );

  scoreboard_match #(
    .DEPTH (DEPTH),
    .IDX_W (SEL_W)
  ) u_match2 (
    .src      (REG_AW_MAX'(src2)),
    .src_used (src2_used),
    .stages   (stages_q),
    .hit      (hit2),
    .youngest (young2)
  );

  assign hit_any1 = |hit1;
  assign hit_any2 = |hit2;

  // A youngest match in stage 0 that is a load cannot be forwarded yet.
  assign load_use = (hit_any1 && (young1 == '0) && stages_q[0].mem_r_en) ||
                    (hit_any2 && (young2 == '0) && stages_q[0].mem_r_en);

  // Stall and forwarding decision; flush masks everything.
  always_comb begin
    stall    = 1'b0;
    fwd_sel1 = SEL_W'(FWD_SEL_RF);
    fwd_sel2 = SEL_W'(FWD_SEL_RF);
    if (!flush) begin
      if (FWD_EN == 0) begin
        stall = issue_valid && (hit_any1 || hit_any2);
      end else begin
        stall = issue_valid && load_use;
        if (hit_any1) fwd_sel1 = young1 + SEL_W'(1);
        if (hit_any2) fwd_sel2 = young2 + SEL_W'(1);
      end
    end
  end

  // Shift the pipeline; stage 0 takes the ID instruction or a bubble.
  always_comb begin
    stages_d    = '0;
    stages_d[0] = '0;
    if (issue_valid && !stall && !flush) begin
      stages_d[0].valid    = 1'b1;
      stages_d[0].dest     = REG_AW_MAX'(issue_dest);
      stages_d[0].wb_en    = issue_wb_en;
      stages_d[0].mem_r_en = issue_mem_r_en;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      stages_d[i] = stages_q[i-1];
    end
  end

  // Saturating stall counter.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stages_q <= '0;
      cnt_q    <= '0;
    end else begin
      stages_q <= stages_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: three scoreboards (forwarding, stall-only, 4-bit counter) share stimulus.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, issue_valid, issue_wb_en, issue_mem_r_en;
  logic [3:0] issue_dest, src1, src2;
  logic       src1_used, src2_used;

  logic        f_stall, s_stall, t_stall;
  logic [1:0]  f_sel1, f_sel2, s_sel1, s_sel2, t_sel1, t_sel2;
  logic [15:0] f_cnt, s_cnt;
  logic [3:0]  t_cnt;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard #(.DEPTH(3), .REG_AW(4), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_mem_r_en(issue_mem_r_en), .src1(src1), .src2(src2),
    .src1_used(src1_used), .src2_used(src2_used), .stall(f_stall), .fwd_sel1(f_sel1),
    .fwd_sel2(f_sel2), .stall_count(f_cnt)
  );

  hazard_scoreboard #(.DEPTH(3), .REG_AW(4), .FWD_EN(0), .CNT_W(16)) u_stl (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_mem_r_en(issue_mem_r_en), .src1(src1), .src2(src2),
    .src1_used(src1_used), .src2_used(src2_used), .stall(s_stall), .fwd_sel1(s_sel1),
    .fwd_sel2(s_sel2), .stall_count(s_cnt)
  );

  hazard_scoreboard #(.DEPTH(3), .REG_AW(4), .FWD_EN(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_wb_en(issue_wb_en), .issue_mem_r_en(issue_mem_r_en), .src1(src1), .src2(src2),
    .src1_used(src1_used), .src2_used(src2_used), .stall(t_stall), .fwd_sel1(t_sel1),
    .fwd_sel2(t_sel2), .stall_count(t_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [3:0] d, input logic wb, input logic ld,
                       input logic [3:0] a, input logic au, input logic [3:0] b, input logic bu);
    issue_valid = v; issue_dest = d; issue_wb_en = wb; issue_mem_r_en = ld;
    src1 = a; src1_used = au; src2 = b; src2_used = bu;
  endtask

  task automatic idle();
    flush = 1'b0;
    issue(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    do_reset();

    // Reset state
    sample();
    check("rst_stall", f_stall, 0);
    check("rst_sel1", f_sel1, 0);
    check("rst_sel2", f_sel2, 0);
    check("rst_cnt", f_cnt, 0);

    // ADD r3 ; SUB r4,r3,r1 -> forward from EXE
    issue(1, 4'd3, 1, 0, 4'd1, 1, 4'd2, 1);
    sample();
    check("add_nostall", f_stall, 0);
    tick();
    issue(1, 4'd4, 1, 0, 4'd3, 1, 4'd1, 1);
    sample();
    check("sub_stall", f_stall, 0);
    check("sub_sel1", f_sel1, 1);
    check("sub_sel2", f_sel2, 0);
    check("sub_stl_stall", s_stall, 1);
    check("sub_stl_sel1", s_sel1, 0);
    tick();

    // LDR r2 ; ADD r5,r2,r2 -> one load-use bubble then forward from stage 1
    do_reset();
    issue(1, 4'd2, 1, 1, 4'd0, 0, 4'd0, 0);
    tick();
    issue(1, 4'd5, 1, 0, 4'd2, 1, 4'd2, 1);
    sample();
    check("lu_stall", f_stall, 1);
    tick();
    sample();
    check("lu_stall_after", f_stall, 0);
    check("lu_sel1", f_sel1, 2);
    check("lu_sel2", f_sel2, 2);
    check("lu_cnt", f_cnt, 1);

    // Stall-only: ADD r3 ; use r3 -> 3 stall cycles
    do_reset();
    issue(1, 4'd3, 1, 0, 4'd0, 0, 4'd0, 0);
    tick();
    issue(1, 4'd7, 1, 0, 4'd3, 1, 4'd0, 0);
    sample();
    check("so_stall0", s_stall, 1);
    tick();
    sample();
    check("so_stall1", s_stall, 1);
    tick();
    sample();
    check("so_stall2", s_stall, 1);
    tick();
    sample();
    check("so_release", s_stall, 0);
    check("so_sel1", s_sel1, 0);
    check("so_cnt", s_cnt, 3);
    check("so_fwd_cnt", f_cnt, 0);

    // Own dest as source is no hazard; youngest producer wins
    do_reset();
    issue(1, 4'd6, 1, 0, 4'd6, 1, 4'd6, 1);
    sample();
    check("self_stall", f_stall, 0);
    check("self_sel1", f_sel1, 0);
    tick();
    issue(1, 4'd3, 1, 0, 4'd0, 0, 4'd0, 0);
    tick();
    issue(1, 4'd5, 1, 0, 4'd0, 0, 4'd0, 0);
    tick();
    issue(1, 4'd3, 1, 0, 4'd0, 0, 4'd0, 0);
    tick();
    issue(1, 4'd8, 1, 0, 4'd3, 1, 4'd5, 1);
    sample();
    check("yw_sel1", f_sel1, 1);
    check("yw_sel2", f_sel2, 2);
    check("yw_stall", f_stall, 0);

    // Load-use with flush in the same cycle
    do_reset();
    issue(1, 4'd2, 1, 1, 4'd0, 0, 4'd0, 0);
    tick();
    issue(1, 4'd2, 1, 0, 4'd2, 1, 4'd0, 0);
    flush = 1'b1;
    sample();
    check("fl_stall", f_stall, 0);
    check("fl_sel1", f_sel1, 0);
    tick();
    flush = 1'b0;
    sample();
    check("fl_bubble_sel1", f_sel1, 2);
    check("fl_bubble_stall", f_stall, 0);
    check("fl_cnt", f_cnt, 0);

    // 20 load-use stalls: 4-bit counter saturates
    do_reset();
    for (int i = 0; i < 20; i++) begin
      issue(1, 4'd2, 1, 1, 4'd0, 0, 4'd0, 0);
      tick();
      issue(1, 4'd5, 0, 0, 4'd2, 1, 4'd0, 0);
      tick();
      tick();
    end
    idle();
    sample();
    check("sat_cnt", t_cnt, 15);
    check("sat_wide_cnt", f_cnt, 20);

    // Reset in the middle of a stall discards in-flight entries
    issue(1, 4'd2, 1, 1, 4'd0, 0, 4'd0, 0);
    tick();
    issue(1, 4'd5, 1, 0, 4'd2, 1, 4'd2, 1);
    sample();
    check("mid_stall", t_stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    check("mid_rst_cnt", t_cnt, 0);
    check("mid_rst_stall", t_stall, 0);
    check("mid_rst_sel1", t_sel1, 0);
    check("mid_rst_sel2", t_sel2, 0);
    check("mid_rst_fcnt", f_cnt, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3, SHALL set the number of tracked in-flight stages after ID (stage 0 = EXE ... stage DEPTH-1 = WB); legal range 1..7.
REQ-002 Parameter REG_AW, default 4, SHALL set the register-address width.
REQ-003 Parameter FWD_EN, default 1, SHALL select the mode: 0 = stall-only, 1 = forwarding with load-use stall.
REQ-004 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  kills the instruction currently in ID (branch taken).
REQ-008 issue_valid  in  1  ID holds an instruction.
REQ-009 issue_dest  in  REG_AW  destination register of the ID instruction.
REQ-010 issue_wb_en  in  1  ID instruction writes issue_dest.
REQ-011 issue_mem_r_en  in  1  ID instruction is a load.
REQ-012 src1 / src2  in  REG_AW each  source registers of the ID instruction.
REQ-013 src1_used / src2_used  in  1 each  the matching source is read.
REQ-014 stall  out  1  hold IF and ID, insert bubble into EXE.
REQ-015 fwd_sel1 / fwd_sel2  out  clog2(DEPTH+1) each  0 = register file, k = result of stage k-1.
REQ-016 stall_count  out  CNT_W  saturating count of stall cycles.

Function
REQ-017 Each stage SHALL hold {valid, dest, wb_en, mem_r_en}; every cycle stage i SHALL load stage i-1 and stage DEPTH-1 SHALL retire.
REQ-018 Stage 0 SHALL load {issue_valid, issue_dest, issue_wb_en, issue_mem_r_en} when issue_valid=1, stall=0 and flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-019 A source SHALL match stage i when srcN_used=1, stage valid=1, wb_en=1 and dest=srcN.
REQ-020 FWD_EN=0: stall SHALL be 1 when issue_valid=1, flush=0 and any source matches any stage; fwd_sel1/2 SHALL be 0.
REQ-021 FWD_EN=1: fwd_selN SHALL equal (lowest matching stage index)+1, or 0 if no match; the youngest producer SHALL win when several stages match.
REQ-022 FWD_EN=1: stall SHALL be 1 only when issue_valid=1, flush=0 and a source's youngest match is stage 0 with mem_r_en=1 (load-use); exactly one bubble results per such hazard.
REQ-023 stall, fwd_sel1 and fwd_sel2 SHALL be combinational from the inputs and current stage contents (zero-cycle latency).
REQ-024 flush=1 SHALL force stall=0 and fwd_sel1/2=0, regardless of hazards.
REQ-025 stall_count SHALL increment by 1 in each cycle with stall=1 and SHALL hold at 2^CNT_W-1 (no wrap-around).
REQ-026 issue_dest equal to a source register of the same instruction SHALL NOT cause a hazard.

Reset
REQ-027 rst=1 at a clock edge SHALL clear all stage valid bits and stall_count; stall and fwd_sel1/2 SHALL then read 0.
REQ-028 rst asserted mid-stall SHALL discard all in-flight entries; the first cycle after reset SHALL show no hazard.

Structure
REQ-029 arm_pkg SHALL hold REG_AW default, the stage-entry struct typedef and the FWD_SEL_RF=0 constant.
REQ-030 One sub-module, scoreboard_match (one source versus all stages -> hit vector plus youngest index), SHALL be instantiated twice.

Verification
REQ-031 FWD_EN=1: ADD r3 then SUB r4,r3,r1 back-to-back -> stall=0, fwd_sel1=1.
REQ-032 FWD_EN=1: LDR r2, then ADD r5,r2,r2 -> stall=1 for 1 cycle; next cycle fwd_sel1=fwd_sel2=2; stall_count=1.
REQ-033 FWD_EN=0, DEPTH=3: ADD r3 then use of r3 -> stall=1 for 3 cycles, then fwd_sel=0; stall_count=3.
REQ-034 r3 written in stages 0 and 2, use r3 -> fwd_sel1=1 (youngest wins).
REQ-035 Load-use hazard with flush=1 in the same cycle -> stall=0, bubble enters stage 0, stall_count unchanged.
REQ-036 CNT_W=4, 20 forced stall cycles -> stall_count=15; then rst=1 -> stall_count=0 and all stages invalid.
